// File: rtl/uart_frame_decoder.sv
// Receive-side frame decoder: hunts for SYNC, gathers 7 payload bytes plus an XOR
// checksum, and updates every enemy-state output at once only when the frame is good.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 40000,
  parameter int         TO_BITS   = 16,
  parameter logic [7:0] HP_INIT   = 8'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic [9:0] xpos_tank_out,
  output logic [9:0] ypos_tank_out,
  output logic [9:0] xpos_bullet_out,
  output logic [9:0] ypos_bullet_out,
  output logic [2:0] direction_for_enemy_out,
  output logic       tank_our_hit_out,
  output logic       obstacle_hit_out,
  output logic [1:0] direction_tank_out,
  output logic [7:0] hp_our_out,
  output logic       frame_valid,
  output logic       chk_err,
  output logic       timeout_err,
  output logic [7:0] err_count
);

  // Handshake: rx_done is a valid-only strobe with no ready; rx_data is consumed in
  // exactly the cycle rx_done is high, so every byte must be accepted when offered.

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  localparam logic [TO_BITS-1:0] TO_LIMIT = TO_BITS'(TIMEOUT);
  localparam logic [TO_BITS-1:0] TO_ONE   = TO_BITS'(1);

  logic [1:0]         state;
  logic [2:0]         idx;
  logic [7:0]         csum;
  logic [55:0]        shadow;
  logic [TO_BITS-1:0] to_cnt;
  logic [TO_BITS-1:0] to_next;

  assign to_next = to_cnt + TO_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                   <= ST_HUNT;
      idx                     <= 3'd0;
      csum                    <= 8'd0;
      shadow                  <= 56'd0;
      to_cnt                  <= '0;
      xpos_tank_out           <= 10'd0;
      ypos_tank_out           <= 10'd0;
      xpos_bullet_out         <= 10'd0;
      ypos_bullet_out         <= 10'd0;
      direction_for_enemy_out <= 3'd0;
      tank_our_hit_out        <= 1'b0;
      obstacle_hit_out        <= 1'b0;
      direction_tank_out      <= 2'd0;
      hp_our_out              <= HP_INIT;
      frame_valid             <= 1'b0;
      chk_err                 <= 1'b0;
      timeout_err             <= 1'b0;
      err_count               <= 8'd0;
    end else begin
      frame_valid <= 1'b0;
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
      if (rx_done) begin
        // A byte always wins over a timeout that would fire in the same cycle.
        to_cnt <= '0;
        case (state)
          ST_HUNT: begin
            if (rx_data == SYNC_BYTE) begin
              state <= ST_PAYLOAD;
              idx   <= 3'd0;
              csum  <= 8'd0;
            end
          end
          ST_PAYLOAD: begin
            // Shifting in MSB-first leaves B0 in shadow[55:48] after seven bytes.
            shadow <= {shadow[47:0], rx_data};
            csum   <= csum ^ rx_data;
            if (idx == 3'd6) begin
              state <= ST_CHECK;
            end else begin
              idx <= idx + 3'd1;
            end
          end
          ST_CHECK: begin
            state <= ST_HUNT;
            if (rx_data == csum) begin
              xpos_tank_out           <= shadow[55:46];
              ypos_tank_out           <= shadow[45:36];
              xpos_bullet_out         <= shadow[35:26];
              ypos_bullet_out         <= shadow[25:16];
              direction_for_enemy_out <= shadow[15:13];
              tank_our_hit_out        <= shadow[12];
              obstacle_hit_out        <= shadow[11];
              direction_tank_out      <= shadow[10:9];
              hp_our_out              <= shadow[8:1];
              frame_valid             <= 1'b1;
            end else begin
              chk_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end else if (state == ST_HUNT) begin
        to_cnt <= '0;
      end else if (to_next == TO_LIMIT) begin
        state       <= ST_HUNT;
        timeout_err <= 1'b1;
        to_cnt      <= '0;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else begin
        to_cnt <= to_next;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: frames are packed 9-byte vectors with
// hand-computed checksums and field values.
module tb_uart_frame_decoder;

  localparam int TIMEOUT = 200;

  // SYNC, B0..B6, CHK
  localparam logic [71:0] FRAME_A     = 72'hA5_FF_C0_00_00_00_00_00_3F;
  localparam logic [71:0] FRAME_A_BAD = 72'hA5_FF_C0_00_00_00_00_00_3E;
  localparam logic [71:0] FRAME_B     = 72'hA5_00_00_00_A5_00_B4_C8_D9;
  localparam logic [71:0] FRAME_C     = 72'hA5_12_34_56_78_9A_BC_DE_F0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic [9:0] xpos_tank_out, ypos_tank_out, xpos_bullet_out, ypos_bullet_out;
  logic [2:0] direction_for_enemy_out;
  logic       tank_our_hit_out, obstacle_hit_out;
  logic [1:0] direction_tank_out;
  logic [7:0] hp_our_out;
  logic       frame_valid, chk_err, timeout_err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  uart_frame_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .rx_done(rx_done),
    .rx_data(rx_data),
    .xpos_tank_out(xpos_tank_out),
    .ypos_tank_out(ypos_tank_out),
    .xpos_bullet_out(xpos_bullet_out),
    .ypos_bullet_out(ypos_bullet_out),
    .direction_for_enemy_out(direction_for_enemy_out),
    .tank_our_hit_out(tank_our_hit_out),
    .obstacle_hit_out(obstacle_hit_out),
    .direction_tank_out(direction_tank_out),
    .hp_our_out(hp_our_out),
    .frame_valid(frame_valid),
    .chk_err(chk_err),
    .timeout_err(timeout_err),
    .err_count(err_count)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // driver: one byte strobed for a single cycle, followed by one idle cycle
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_bytes(input logic [71:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(f[71-8*i -: 8]);
  endtask

  task automatic check_fields(input string tag,
                              input logic [9:0] xt, input logic [9:0] yt,
                              input logic [9:0] xb, input logic [9:0] yb,
                              input logic [2:0] de, input logic th, input logic oh,
                              input logic [1:0] dt, input logic [7:0] hp);
    check({tag, ".xpos_tank"},   32'(xpos_tank_out), 32'(xt));
    check({tag, ".ypos_tank"},   32'(ypos_tank_out), 32'(yt));
    check({tag, ".xpos_bullet"}, 32'(xpos_bullet_out), 32'(xb));
    check({tag, ".ypos_bullet"}, 32'(ypos_bullet_out), 32'(yb));
    check({tag, ".dir_enemy"},   32'(direction_for_enemy_out), 32'(de));
    check({tag, ".tank_hit"},    32'(tank_our_hit_out), 32'(th));
    check({tag, ".obs_hit"},     32'(obstacle_hit_out), 32'(oh));
    check({tag, ".dir_tank"},    32'(direction_tank_out), 32'(dt));
    check({tag, ".hp"},          32'(hp_our_out), 32'(hp));
  endtask

  task automatic check_pulses(input string tag, input logic fv, input logic ce, input logic te);
    check({tag, ".frame_valid"}, 32'(frame_valid), 32'(fv));
    check({tag, ".chk_err"},     32'(chk_err), 32'(ce));
    check({tag, ".timeout_err"}, 32'(timeout_err), 32'(te));
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_fields("reset", 10'd0, 10'd0, 10'd0, 10'd0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd100);
    check_pulses("reset", 1'b0, 1'b0, 1'b0);
    check("reset.err_count", 32'(err_count), 32'd0);

    // valid frame A: xpos_tank all ones, everything else zero
    send_bytes(FRAME_A, 0, 8);
    check_pulses("frame_a", 1'b1, 1'b0, 1'b0);
    check_fields("frame_a", 10'd1023, 10'd0, 10'd0, 10'd0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd0);
    check("frame_a.err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    check("frame_a.pulse_width", 32'(frame_valid), 32'd0);

    // bad checksum after reset: outputs keep reset values
    apply_reset();
    send_bytes(FRAME_A_BAD, 0, 8);
    check_pulses("bad_chk", 1'b0, 1'b1, 1'b0);
    check_fields("bad_chk", 10'd0, 10'd0, 10'd0, 10'd0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd100);
    check("bad_chk.err_count", 32'(err_count), 32'd1);
    @(negedge clk);
    check("bad_chk.pulse_width", 32'(chk_err), 32'd0);

    // garbage then frame B whose payload byte B3 equals SYNC
    send_byte(8'h12);
    send_byte(8'h34);
    check("garbage.frame_valid", 32'(frame_valid), 32'd0);
    send_bytes(FRAME_B, 0, 8);
    check_pulses("frame_b", 1'b1, 1'b0, 1'b0);
    check_fields("frame_b", 10'd0, 10'd0, 10'd41, 10'd256, 3'd5, 1'b1, 1'b0, 2'd2, 8'd100);
    check("frame_b.err_count", 32'(err_count), 32'd1);

    // inter-byte timeout after SYNC + 3 payload bytes
    send_bytes(FRAME_C, 0, 3);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("timeout.before", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("timeout.at_limit", 32'(timeout_err), 32'd1);
    check("timeout.err_count", 32'(err_count), 32'd2);
    check("timeout.fields_kept", 32'(xpos_bullet_out), 32'd41);
    @(negedge clk);
    check("timeout.pulse_width", 32'(timeout_err), 32'd0);
    send_bytes(FRAME_C, 0, 8);
    check_pulses("frame_c", 1'b1, 1'b0, 1'b0);
    check_fields("frame_c", 10'd72, 10'd837, 10'd414, 10'd154, 3'd5, 1'b1, 1'b1, 2'd2, 8'd111);

    // byte arrives in the very cycle the timeout would fire
    send_bytes(FRAME_B, 0, 3);
    repeat (TIMEOUT - 2) @(negedge clk);
    send_byte(FRAME_B[71-8*4 -: 8]);
    check("coincide.timeout_err", 32'(timeout_err), 32'd0);
    send_bytes(FRAME_B, 5, 8);
    check_pulses("coincide", 1'b1, 1'b0, 1'b0);
    check_fields("coincide", 10'd0, 10'd0, 10'd41, 10'd256, 3'd5, 1'b1, 1'b0, 2'd2, 8'd100);
    check("coincide.err_count", 32'(err_count), 32'd2);

    // err_count saturation over 260 bad frames
    apply_reset();
    for (int n = 1; n <= 260; n++) begin
      send_bytes(FRAME_A_BAD, 0, 8);
      if (n == 1 || n == 254 || n == 255 || n == 260)
        check($sformatf("saturate.err_count_%0d", n), 32'(err_count), (n > 255) ? 32'd255 : 32'(n));
    end
    check("saturate.chk_err", 32'(chk_err), 32'd1);
    check("saturate.hp", 32'(hp_our_out), 32'd100);

    // reset in the middle of a frame
    send_bytes(FRAME_C, 0, 8);
    check("midreset.pre_valid", 32'(frame_valid), 32'd1);
    send_bytes(FRAME_C, 0, 4);
    apply_reset();
    check_fields("midreset", 10'd0, 10'd0, 10'd0, 10'd0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd100);
    check_pulses("midreset", 1'b0, 1'b0, 1'b0);
    check("midreset.err_count", 32'(err_count), 32'd0);
    send_bytes(FRAME_C, 5, 8);
    check_pulses("midreset.tail", 1'b0, 1'b0, 1'b0);
    check("midreset.tail_xpos", 32'(xpos_tank_out), 32'd0);
    send_bytes(FRAME_B, 0, 8);
    check_pulses("after_reset", 1'b1, 1'b0, 1'b0);
    check_fields("after_reset", 10'd0, 10'd0, 10'd41, 10'd256, 3'd5, 1'b1, 1'b0, 2'd2, 8'd100);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
